mul_hilo_ctrl: RTL and testbench

//  Multi-cycle sequencer and HI/LO register file around the combinational MUL32 array.

---
 rtl/mdu_pkg.sv | 11 +
 rtl/mul_hilo_ctrl.sv | 91 +++++++++
 tb/tb_mul_hilo_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit control blocks.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mul_hilo_ctrl.sv
// Multicycle sequencer and HI/LO register file around the combinational MUL32 array.
// Optional build macro: MUL_ZERO_SKIP_EN (zero operand completes in one cycle, never enters SETTLE).
//
// state  | meaning
// IDLE   | waiting for i_start; MTHI/MTLO are applied here
// SETTLE | operands held steady on mul_a/mul_b while MUL32 resolves; capture when cnt hits 0
module mul_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH         = MDU_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    input  logic               i_hi_wr,
    input  logic               i_lo_wr,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("mul_hilo_ctrl: SETTLE_CYCLES must be at least 1");
    end

    mdu_state_e    state;
    logic [CW-1:0] cnt;

    // State is a flop, so busy is a registered output without a second copy.
    assign o_busy = (state == SETTLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mul_a <= i_a;
                        mul_b <= i_b;
`ifdef MUL_ZERO_SKIP_EN
                        if ((i_a == '0) || (i_b == '0)) begin
                            o_hi   <= '0;
                            o_lo   <= '0;
                            o_done <= 1'b1;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= SETTLE;
                        end
`else
                        cnt   <= CNT_LOAD;
                        state <= SETTLE;
`endif
                    end else begin
                        if (i_hi_wr) o_hi <= i_wdata;
                        if (i_lo_wr) o_lo <= i_wdata;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        {o_hi, o_lo} <= mul_p;
                        o_done       <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a behavioural MUL32 stand-in and a cycle model.
module tb_mul_hilo_ctrl;

    localparam int W  = 32;
    localparam int SC = 2;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic [W-1:0]   i_a = '0;
    logic [W-1:0]   i_b = '0;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           i_hi_wr = 1'b0;
    logic           i_lo_wr = 1'b0;
    logic [W-1:0]   i_wdata = '0;
    logic           o_busy, o_done;
    logic [W-1:0]   o_hi, o_lo;

    int n_chk  = 0;
    int n_fail = 0;

    mul_hilo_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p),
        .i_hi_wr (i_hi_wr),
        .i_lo_wr (i_lo_wr),
        .i_wdata (i_wdata),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    // Combinational signed multiplier standing in for MUL32.
    assign mul_p = 64'($signed(mul_a)) * 64'($signed(mul_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a countdown of remaining settle cycles and a precomputed product.
    logic [W-1:0] m_hi, m_lo, m_ma, m_mb;
    logic         m_done, m_busy;
    logic [63:0]  m_prod;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_ma = '0; m_mb = '0;
            m_done = 1'b0; m_busy = 1'b0; m_left = 0; m_prod = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                    m_done = 1'b1;
                end
            end else if (i_start) begin
                longint pa, pb;
                pa = longint'($signed(i_a));
                pb = longint'($signed(i_b));
                m_prod = 64'(pa * pb);
                m_ma = i_a;
                m_mb = i_b;
                if (ZSKIP && (i_a == 0 || i_b == 0)) begin
                    m_hi = '0; m_lo = '0; m_done = 1'b1;
                end else begin
                    m_left = SC;
                end
            end else begin
                if (i_hi_wr) m_hi = i_wdata;
                if (i_lo_wr) m_lo = i_wdata;
            end
            m_busy = (m_left > 0);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_hi",    64'(o_hi),   64'(m_hi));
        chk("cyc_lo",    64'(o_lo),   64'(m_lo));
        chk("cyc_done",  64'(o_done), 64'(m_done));
        chk("cyc_busy",  64'(o_busy), 64'(m_busy));
        chk("cyc_mul_a", 64'(mul_a),  64'(m_ma));
        chk("cyc_mul_b", 64'(mul_b),  64'(m_mb));
    end

    // Called at a negedge: drives a start, then waits (bounded) for o_done.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int elat, input int ebusy);
        int lat = 0;
        int nbusy = 0;
        i_start = 1'b1; i_a = a; i_b = b;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) i_start = 1'b0;
            if (o_busy) nbusy++;
            if (o_done) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_lat"},  64'(lat),   64'(elat));
        chk({nm, "_busy"}, 64'(nbusy), 64'(ebusy));
        chk({nm, "_hi"},   64'(o_hi),  64'(ehi));
        chk({nm, "_lo"},   64'(o_lo),  64'(elo));
    endtask

    initial begin
        int ndone;
        int lat_n, busy_n;
        lat_n  = SC + 1;
        busy_n = SC;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_hi",   64'(o_hi),   64'd0);
        chk("rst_mula", 64'(mul_a),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Products with sign, then the extreme operands; issued back to back.
        run_op("t1_neg",  32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, lat_n, busy_n);
        run_op("t2_minsq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, lat_n, busy_n);
        run_op("t2_mxmn",  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, lat_n, busy_n);

        // Start during SETTLE is ignored.
        @(negedge clk);
        i_start = 1'b1; i_a = 32'd2; i_b = 32'd3;
        @(negedge clk);
        i_a = 32'd5; i_b = 32'd5;
        @(negedge clk);
        i_start = 1'b0;
        chk("t3_mula_hold", 64'(mul_a), 64'd2);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_done) ndone++;
            @(negedge clk);
        end
        chk("t3_ndone", 64'(ndone), 64'd1);
        chk("t3_hi", 64'(o_hi), 64'd0);
        chk("t3_lo", 64'(o_lo), 64'd6);

        // Reset mid-SETTLE abandons the operation.
        i_start = 1'b1; i_a = 32'd7; i_b = 32'd9;
        @(negedge clk);
        i_start = 1'b0;
        chk("t4_busy_pre", 64'(o_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_busy", 64'(o_busy), 64'd0);
        chk("t4_done", 64'(o_done), 64'd0);
        chk("t4_hi",   64'(o_hi),   64'd0);
        chk("t4_lo",   64'(o_lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("t4_nodone", 64'(ndone), 64'd0);

        // MTHI in IDLE, MTLO dropped during SETTLE, both together, and with start.
        i_hi_wr = 1'b1; i_wdata = 32'h1234_5678;
        @(negedge clk);
        i_hi_wr = 1'b0;
        chk("t5_mthi", 64'(o_hi), 64'h1234_5678);
        chk("t5_lo_keep", 64'(o_lo), 64'd0);
        i_start = 1'b1; i_a = 32'd3; i_b = 32'd4;
        @(negedge clk);
        i_start = 1'b0;
        i_lo_wr = 1'b1; i_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_lo_wr = 1'b0;
        chk("t5_mtlo_drop", 64'(o_lo), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5_cap_lo", 64'(o_lo), 64'd12);
        i_hi_wr = 1'b1; i_lo_wr = 1'b1; i_wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        i_hi_wr = 1'b0; i_lo_wr = 1'b0;
        chk("t5_both_hi", 64'(o_hi), 64'hA5A5_0F0F);
        chk("t5_both_lo", 64'(o_lo), 64'hA5A5_0F0F);
        i_start = 1'b1; i_a = 32'd1; i_b = 32'd1; i_hi_wr = 1'b1; i_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        i_start = 1'b0; i_hi_wr = 1'b0;
        chk("t5_start_drop", 64'(o_hi), 64'hA5A5_0F0F);
        repeat (3) @(negedge clk);

        // Zero operand: short path only when the skip feature is built in.
        if (ZSKIP) run_op("t6_zero", 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1, 0);
        else       run_op("t6_zero", 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0, lat_n, busy_n);
        chk("t6_mulb", 64'(mul_b), 64'h7FFF_FFFF);
        run_op("t6_after", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, lat_n, busy_n);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
